// File: rtl/nibble_serial_adder_ctrl.sv
// Valid/ready sequenced WIDTH-bit adder that reuses one 4-bit ripple slice, one nibble per clock.
// Define SERIAL_ADDER_SUBTRACT_EN to add the op input (op=1 computes a-b; overflow then flags a borrow).
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             op_w;
  logic [IDX_W+1:0] shamt;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             rip_c, nib_co;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  assign op_w = op;
`else
  assign op_w = 1'b0;
`endif

  // Shared 4-bit ripple slice: four full adders chained from the registered carry.
  always_comb begin
    shamt = {idx_q, 2'b00};
    nib_a = 4'(a_q >> shamt);
    nib_b = 4'(b_q >> shamt);
    nib_s = '0;
    rip_c = carry_q;
    for (int i = 0; i < 4; i++) begin
      nib_s[i] = nib_a[i] ^ nib_b[i] ^ rip_c;
      rip_c    = (nib_a[i] & nib_b[i]) | (rip_c & (nib_a[i] ^ nib_b[i]));
    end
    nib_co = rip_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtraction is a + ~b + 1, so invert b once at accept.
          a_d        = a;
          b_d        = op_w ? ~b : b;
          op_d       = op_w;
          carry_d    = op_w;
          idx_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = (acc_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(nib_s) << shamt);
        carry_d = nib_co;
        if (idx_q == LAST_IDX) begin
          sum_d       = acc_d;
          overflow_d  = nib_co ^ op_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed and random operations at WIDTH=16 and WIDTH=4,
// checked against plain-arithmetic sums. Subtract cases run when SERIAL_ADDER_SUBTRACT_EN is defined.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [W-1:0] a, b, sum;
  logic         op_s;

  logic         in_valid4, in_ready4, out_valid4, out_ready4, overflow4, busy4;
  logic [3:0]   a4, b4, sum4;

  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .op(op_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow), .busy(busy)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .op(1'b0),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .overflow(overflow4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for result, optional backpressure, handoff.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic sub,
                        input int hold, input bit early, input bit junk);
    logic [W:0]   full;
    logic [W-1:0] exp_sum, prev_sum;
    logic         exp_ovf;
    int           cnt;
    if (sub) begin
      exp_sum = xa - xb;
      exp_ovf = (xa < xb);
    end else begin
      full    = {1'b0, xa} + {1'b0, xb};
      exp_sum = full[W-1:0];
      exp_ovf = full[W];
    end
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    prev_sum  = sum;
    in_valid  = 1'b1;
    a         = xa;
    b         = xb;
    op_s      = sub;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    check("accept_busy", busy, 1);
    check("accept_in_ready", in_ready, 0);
    check("accept_out_valid", out_valid, 0);
    if (junk) begin
      a    = W'($urandom);
      b    = W'($urandom);
      op_s = ~sub;
    end else begin
      in_valid = 1'b0;
    end
    out_ready = early;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 4 * NIB + 8) begin
      check("run_sum_hidden", sum, prev_sum);
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, NIB);
    check("sum", sum, exp_sum);
    check("overflow", overflow, exp_ovf);
    check("done_in_ready", in_ready, 0);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_sum", sum, exp_sum);
        check("hold_ovf", overflow, exp_ovf);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
    check("handoff_busy", busy, 0);
  endtask

  task automatic run4(input logic [3:0] xa, input logic [3:0] xb);
    logic [4:0] e;
    e = {1'b0, xa} + {1'b0, xb};
    @(negedge clk);
    in_valid4 = 1'b1;
    a4 = xa;
    b4 = xb;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    check("w4_run_valid", out_valid4, 0);
    @(posedge clk);
    @(negedge clk);
    check("w4_valid", out_valid4, 1);
    check("w4_sum", sum4, e[3:0]);
    check("w4_ovf", overflow4, e[4]);
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    check("w4_handoff", out_valid4, 0);
  endtask

  initial begin
    logic sub_r;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op_s = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", overflow, 0);
    check("rst_w4_in_ready", in_ready4, 1);
    rst = 1'b0;

    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h0FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'hABCD, 16'h1357, 1'b0, 5, 1'b0, 1'b1);

    // Abort after two nibbles; the previous nonzero sum must be cleared at once.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h1234, 16'h4321, 1'b0, 1, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUBTRACT_EN
    run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 0, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
`ifdef SERIAL_ADDER_SUBTRACT_EN
      sub_r = 1'($urandom_range(0, 1));
`else
      sub_r = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), sub_r, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    run4(4'hF, 4'hF);
    for (int n = 0; n < 10; n++) run4(4'($urandom), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
